// File: rtl/ddr_cmd_responder.sv
// ddr_cmd_responder
//   Memory-side model/monitor of a DDR SDRAM command bus. Samples the command
//   pins on the rising edge of clk133 and decodes each command. It walks the
//   JEDEC power-up sequence, holds the mode and extended mode registers and
//   tracks which banks are open. It also checks command spacing (tRP/tMRD/tRFC)
//   and legality, and reports the highest-priority violation.
//
// Ports
//   clk133      in   command sample clock (rising edge)
//   rst         in   asynchronous active-high reset
//   sd_CKE      in   clock enable; 0 = command ignored (busy still counts down)
//   sd_CS       in   chip select, active low; 1 = NOP
//   sd_RAS/CAS/WE in command bits {RAS,CAS,WE}
//   sd_A        in   [12:0] address / mode value (A10 = all-banks for PRE)
//   sd_BA       in   [1:0] bank address
//   initDone    out  power-up sequence complete
//   modeReg     out  [12:0] last accepted LMR value with BA=00
//   extModeReg  out  [12:0] last accepted LMR value with BA=01
//   bankOpen    out  [3:0] one bit per bank, 1 = row active
//   violation   out  one-cycle pulse on an illegal command
//   violCode    out  [2:0] 0 none, 1 SEQ, 2 TIMING, 3 BANK, 4 MODE (held)
//   errorCount  out  [7:0] violations seen, saturating at 255
//   refreshCnt  out  [15:0] accepted AUTO REFRESH commands, wraps
//   dbgState    out  [3:0] init FSM state: 0 WAIT_CKE, 1 PRE1, 2 EMR, 3 MR1,
//                    4 PRE2, 5 REF1, 6 REF2, 7 MR2, 8 READY
//
// There is no flow control: every sampled cycle is a command, and every
// registered output reflects the commands sampled up to the previous edge.
module ddr_cmd_responder #(
   parameter int T_RP  = 3,
   parameter int T_MRD = 2,
   parameter int T_RFC = 11
) (
   input  logic        clk133,
   input  logic        rst,
   input  logic        sd_CKE,
   input  logic        sd_CS,
   input  logic        sd_RAS,
   input  logic        sd_CAS,
   input  logic        sd_WE,
   input  logic [12:0] sd_A,
   input  logic [1:0]  sd_BA,
   output logic        initDone,
   output logic [12:0] modeReg,
   output logic [12:0] extModeReg,
   output logic [3:0]  bankOpen,
   output logic        violation,
   output logic [2:0]  violCode,
   output logic [7:0]  errorCount,
   output logic [15:0] refreshCnt,
   output logic [3:0]  dbgState
);

   typedef enum logic [3:0] {
      S_WAIT_CKE = 4'd0, S_PRE1 = 4'd1, S_EMR = 4'd2, S_MR1 = 4'd3,
      S_PRE2 = 4'd4, S_REF1 = 4'd5, S_REF2 = 4'd6, S_MR2 = 4'd7,
      S_READY = 4'd8
   } state_t;

   localparam logic [2:0] C_LMR = 3'b000, C_AREF = 3'b001, C_PRE = 3'b010,
                          C_ACT = 3'b011, C_WR = 3'b100, C_RD = 3'b101,
                          C_BST = 3'b110, C_NOP = 3'b111;

   localparam logic [2:0] V_NONE = 3'd0, V_SEQ = 3'd1, V_TIM = 3'd2,
                          V_BANK = 3'd3, V_MODE = 3'd4;

   state_t      state_q, state_d;
   logic [7:0]  busy_q, busy_d;
   logic [12:0] mode_q, mode_d, ext_q, ext_d;
   logic [3:0]  bank_q, bank_d;
   logic        viol_q, viol_d;
   logic [2:0]  code_q, code_d;
   logic [7:0]  err_q, err_d;
   logic [15:0] ref_q, ref_d;

   logic [2:0]  cmd;
   logic        cmd_nop;
   logic        seq_ok;
   logic        bank_err;
   logic        mode_err;
   logic [2:0]  code_sel;

   // CS high forces NOP; BST has no meaning to this model and is a NOP too.
   assign cmd     = sd_CS ? C_NOP : {sd_RAS, sd_CAS, sd_WE};
   assign cmd_nop = (cmd == C_NOP) || (cmd == C_BST);

   // ---------------- state register ----------------
   always_ff @(posedge clk133 or posedge rst) begin
      if (rst) begin
         state_q <= S_WAIT_CKE;
         busy_q  <= '0;
         mode_q  <= '0;
         ext_q   <= '0;
         bank_q  <= '0;
         viol_q  <= 1'b0;
         code_q  <= V_NONE;
         err_q   <= '0;
         ref_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         mode_q  <= mode_d;
         ext_q   <= ext_d;
         bank_q  <= bank_d;
         viol_q  <= viol_d;
         code_q  <= code_d;
         err_q   <= err_d;
         ref_q   <= ref_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d  = state_q;
      busy_d   = (busy_q != 8'd0) ? busy_q - 8'd1 : 8'd0;
      mode_d   = mode_q;
      ext_d    = ext_q;
      bank_d   = bank_q;
      viol_d   = 1'b0;
      code_d   = code_q;
      err_d    = err_q;
      ref_d    = ref_q;
      seq_ok   = 1'b0;
      bank_err = 1'b0;
      mode_err = 1'b0;
      code_sel = V_NONE;

      if (state_q == S_WAIT_CKE) begin
         // The command sampled with the first CKE=1 only starts the sequence.
         if (sd_CKE) state_d = S_PRE1;
      end else if (sd_CKE && !cmd_nop) begin
         case (state_q)
            S_PRE1, S_PRE2: seq_ok = (cmd == C_PRE) && sd_A[10];
            S_EMR:          seq_ok = (cmd == C_LMR) && (sd_BA == 2'b01);
            S_MR1, S_MR2:   seq_ok = (cmd == C_LMR) && (sd_BA == 2'b00);
            S_REF1, S_REF2: seq_ok = (cmd == C_AREF);
            default:        seq_ok = 1'b1;
         endcase

         if (state_q == S_READY) begin
            case (cmd)
               C_ACT:         bank_err = bank_q[sd_BA];
               C_RD, C_WR:    bank_err = !bank_q[sd_BA];
               C_AREF, C_LMR: bank_err = (bank_q != 4'd0);
               default:       bank_err = 1'b0;
            endcase
         end

         mode_err = (cmd == C_LMR) && (sd_BA == 2'b00) &&
                    !((sd_A[2:0] inside {3'b001, 3'b010, 3'b011}) &&
                      (sd_A[6:4] inside {3'b010, 3'b011, 3'b110}));

         if (!seq_ok)              code_sel = V_SEQ;
         else if (busy_q != 8'd0)  code_sel = V_TIM;
         else if (bank_err)        code_sel = V_BANK;
         else if (mode_err)        code_sel = V_MODE;

         if (code_sel != V_NONE) begin
            // A rejected command leaves everything alone except the error report.
            viol_d = 1'b1;
            code_d = code_sel;
            err_d  = (err_q == 8'hFF) ? 8'hFF : err_q + 8'd1;
         end else begin
            case (cmd)
               C_PRE: begin
                  busy_d = 8'(T_RP - 1);
                  if (sd_A[10]) bank_d = 4'd0;
                  else          bank_d[sd_BA] = 1'b0;
               end
               C_LMR: begin
                  busy_d = 8'(T_MRD - 1);
                  if (sd_BA == 2'b00)      mode_d = sd_A;
                  else if (sd_BA == 2'b01) ext_d  = sd_A;
               end
               C_AREF: begin
                  busy_d = 8'(T_RFC - 1);
                  ref_d  = ref_q + 16'd1;
               end
               C_ACT:   bank_d[sd_BA] = 1'b1;
               default: ;
            endcase

            case (state_q)
               S_PRE1:  state_d = S_EMR;
               S_EMR:   state_d = S_MR1;
               S_MR1:   state_d = S_PRE2;
               S_PRE2:  state_d = S_REF1;
               S_REF1:  state_d = S_REF2;
               S_REF2:  state_d = S_MR2;
               S_MR2:   state_d = S_READY;
               default: state_d = state_q;
            endcase
         end
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      initDone   = (state_q == S_READY);
      modeReg    = mode_q;
      extModeReg = ext_q;
      bankOpen   = bank_q;
      violation  = viol_q;
      violCode   = code_q;
      errorCount = err_q;
      refreshCnt = ref_q;
      dbgState   = state_q;
   end

endmodule
